// File: rtl/lifo_stack_master.sv
// Command front-end for an edge-triggered 4-bit LIFO stack. Turns push/pop/clear/status
// commands into timed stack strobes, returns sampled results, and cross-checks the stack's
// flags against a shadow occupancy count.
module lifo_stack_master #(
  parameter int unsigned DATA_W     = 4,
  parameter int unsigned CAPACITY   = 7,
  parameter int unsigned OCC_W      = 4,
  parameter int unsigned STROBE_CYC = 2,
  parameter int unsigned SETTLE_CYC = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_invalid,
  output logic              rsp_empty,
  output logic              rsp_full,
  output logic [OCC_W-1:0]  occupancy,
  output logic              sync_err,
  output logic              stk_rst,
  output logic              stk_enable,
  output logic              stk_push,
  output logic              stk_pop,
  output logic [DATA_W-1:0] stk_data_in,
  input  logic [DATA_W-1:0] stk_data_out,
  input  logic              stk_empty,
  input  logic              stk_full,
  input  logic              stk_invalid
);

  localparam logic [2:0] INIT   = 3'd0;
  localparam logic [2:0] IDLE   = 3'd1;
  localparam logic [2:0] SETUP  = 3'd2;
  localparam logic [2:0] STROBE = 3'd3;
  localparam logic [2:0] SETTLE = 3'd4;
  localparam logic [2:0] RESP   = 3'd5;

  localparam logic [1:0] OP_STATUS = 2'b00;
  localparam logic [1:0] OP_PUSH   = 2'b01;
  localparam logic [1:0] OP_POP    = 2'b10;
  localparam logic [1:0] OP_CLEAR  = 2'b11;

  localparam int unsigned CntW = 8;
  localparam logic [OCC_W-1:0] OccCap = OCC_W'(CAPACITY);

  logic [2:0]        state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [1:0]        op_q, op_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_invalid_q, rsp_invalid_d;
  logic              rsp_empty_q, rsp_empty_d;
  logic              rsp_full_q, rsp_full_d;
  logic [OCC_W-1:0]  occupancy_q, occupancy_d;
  logic              sync_err_q, sync_err_d;
  logic              stk_rst_q, stk_rst_d;
  logic              stk_enable_q, stk_enable_d;
  logic              stk_push_q, stk_push_d;
  logic              stk_pop_q, stk_pop_d;
  logic [DATA_W-1:0] stk_data_in_q, stk_data_in_d;

  logic [OCC_W-1:0]  occ_new;
  logic              exp_inv;
  logic              mismatch;
  logic              settle_last;

  // Shadow occupancy after the latched op, and whether the stack's flags disagree with it.
  always_comb begin
    occ_new = occupancy_q;
    exp_inv = 1'b0;
    case (op_q)
      OP_PUSH: begin
        if (occupancy_q < OccCap) occ_new = occupancy_q + OCC_W'(1);
        else                      exp_inv = 1'b1;
      end
      OP_POP: begin
        if (occupancy_q != '0) occ_new = occupancy_q - OCC_W'(1);
        else                   exp_inv = 1'b1;
      end
      OP_CLEAR: occ_new = '0;
      default:  ;
    endcase
    mismatch = (stk_empty != (occ_new == '0)) ||
               (stk_full != (occ_new == OccCap)) ||
               (stk_invalid != exp_inv);
  end

  // Status skips the strobe and settles for a single cycle regardless of SETTLE_CYC.
  assign settle_last = (op_q == OP_STATUS) || (cnt_q == CntW'(SETTLE_CYC - 1));

  // Sequencer: next-state and next-output values.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    op_d          = op_q;
    cmd_ready_d   = cmd_ready_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_data_d    = rsp_data_q;
    rsp_invalid_d = rsp_invalid_q;
    rsp_empty_d   = rsp_empty_q;
    rsp_full_d    = rsp_full_q;
    occupancy_d   = occupancy_q;
    sync_err_d    = sync_err_q;
    stk_rst_d     = stk_rst_q;
    stk_enable_d  = stk_enable_q;
    stk_push_d    = stk_push_q;
    stk_pop_d     = stk_pop_q;
    stk_data_in_d = stk_data_in_q;
    case (state_q)
      INIT: begin
        if (cnt_q == CntW'(STROBE_CYC - 1)) begin
          stk_rst_d   = 1'b0;
          cmd_ready_d = 1'b1;
          cnt_d       = '0;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          op_d        = cmd_op;
          cmd_ready_d = 1'b0;
          cnt_d       = '0;
          if (cmd_op == OP_STATUS) begin
            state_d = SETTLE;
          end else begin
            state_d    = SETUP;
            stk_push_d = (cmd_op == OP_PUSH);
            stk_pop_d  = (cmd_op == OP_POP);
            if (cmd_op == OP_PUSH) stk_data_in_d = cmd_data;
          end
        end
      end
      SETUP: begin
        cnt_d   = '0;
        state_d = STROBE;
        if (op_q == OP_CLEAR) stk_rst_d    = 1'b1;
        else                  stk_enable_d = 1'b1;
      end
      STROBE: begin
        if (cnt_q == CntW'(STROBE_CYC - 1)) begin
          stk_enable_d = 1'b0;
          stk_rst_d    = 1'b0;
          cnt_d        = '0;
          state_d      = SETTLE;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      SETTLE: begin
        if (settle_last) begin
          if (op_q == OP_POP) rsp_data_d = stk_data_out;
          rsp_invalid_d = stk_invalid;
          rsp_empty_d   = stk_empty;
          rsp_full_d    = stk_full;
          occupancy_d   = occ_new;
          // A completed clear resets the sticky error unless the clear itself disagrees.
          sync_err_d    = (op_q == OP_CLEAR) ? mismatch : (sync_err_q | mismatch);
          rsp_valid_d   = 1'b1;
          stk_push_d    = 1'b0;
          stk_pop_d     = 1'b0;
          stk_data_in_d = '0;
          cnt_d         = '0;
          state_d       = RESP;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        cnt_d     = '0;
        stk_rst_d = 1'b1;
        state_d   = INIT;
      end
    endcase
  end

  // State and registered outputs; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= INIT;
      cnt_q         <= '0;
      op_q          <= OP_STATUS;
      cmd_ready_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      rsp_invalid_q <= 1'b0;
      rsp_empty_q   <= 1'b1;
      rsp_full_q    <= 1'b0;
      occupancy_q   <= '0;
      sync_err_q    <= 1'b0;
      stk_rst_q     <= 1'b1;
      stk_enable_q  <= 1'b0;
      stk_push_q    <= 1'b0;
      stk_pop_q     <= 1'b0;
      stk_data_in_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      op_q          <= op_d;
      cmd_ready_q   <= cmd_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      rsp_invalid_q <= rsp_invalid_d;
      rsp_empty_q   <= rsp_empty_d;
      rsp_full_q    <= rsp_full_d;
      occupancy_q   <= occupancy_d;
      sync_err_q    <= sync_err_d;
      stk_rst_q     <= stk_rst_d;
      stk_enable_q  <= stk_enable_d;
      stk_push_q    <= stk_push_d;
      stk_pop_q     <= stk_pop_d;
      stk_data_in_q <= stk_data_in_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_invalid = rsp_invalid_q;
  assign rsp_empty   = rsp_empty_q;
  assign rsp_full    = rsp_full_q;
  assign occupancy   = occupancy_q;
  assign sync_err    = sync_err_q;
  assign stk_rst     = stk_rst_q;
  assign stk_enable  = stk_enable_q;
  assign stk_push    = stk_push_q;
  assign stk_pop     = stk_pop_q;
  assign stk_data_in = stk_data_in_q;

endmodule

// File: tb/tb_lifo_stack_master.sv
// Bench for lifo_stack_master: attached behavioural LIFO, queue-based reference of the
// expected responses, directed scenarios followed by random commands.
module tb_lifo_stack_master;

  localparam logic [1:0] OP_STATUS = 2'b00;
  localparam logic [1:0] OP_PUSH   = 2'b01;
  localparam logic [1:0] OP_POP    = 2'b10;
  localparam logic [1:0] OP_CLEAR  = 2'b11;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid, cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_data;
  logic       rsp_valid, rsp_ready;
  logic [3:0] rsp_data;
  logic       rsp_invalid, rsp_empty, rsp_full;
  logic [3:0] occupancy;
  logic       sync_err;
  logic       stk_rst, stk_enable, stk_push, stk_pop;
  logic [3:0] stk_data_in, stk_data_out;
  logic       stk_empty, stk_full, stk_invalid;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  lifo_stack_master dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_data     (cmd_data),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .rsp_invalid  (rsp_invalid),
    .rsp_empty    (rsp_empty),
    .rsp_full     (rsp_full),
    .occupancy    (occupancy),
    .sync_err     (sync_err),
    .stk_rst      (stk_rst),
    .stk_enable   (stk_enable),
    .stk_push     (stk_push),
    .stk_pop      (stk_pop),
    .stk_data_in  (stk_data_in),
    .stk_data_out (stk_data_out),
    .stk_empty    (stk_empty),
    .stk_full     (stk_full),
    .stk_invalid  (stk_invalid)
  );

  // Attached 7-entry stack: acts on the rising edge of enable, cleared by its reset.
  logic [3:0] m_mem [0:7];
  logic [3:0] m_sp   = 4'd0;
  logic [3:0] m_dout = 4'd0;
  logic       m_inv  = 1'b0;
  logic       force_e0 = 1'b0;

  always @(posedge stk_enable or posedge stk_rst) begin
    if (stk_rst) begin
      m_sp   <= 4'd0;
      m_inv  <= 1'b0;
      m_dout <= 4'd0;
    end else if (stk_push) begin
      if (m_sp < 4'd7) begin
        m_mem[m_sp[2:0]] <= stk_data_in;
        m_sp  <= m_sp + 4'd1;
        m_inv <= 1'b0;
      end else begin
        m_inv <= 1'b1;
      end
    end else if (stk_pop) begin
      if (m_sp > 4'd0) begin
        m_dout <= m_mem[3'(m_sp - 4'd1)];
        m_sp   <= m_sp - 4'd1;
        m_inv  <= 1'b0;
      end else begin
        m_inv <= 1'b1;
      end
    end
  end

  assign stk_empty    = force_e0 ? 1'b0 : (m_sp == 4'd0);
  assign stk_full     = (m_sp == 4'd7);
  assign stk_invalid  = m_inv;
  assign stk_data_out = m_dout;

  // Reference state
  logic [3:0] ref_q[$];
  logic [3:0] ref_dout;
  logic [3:0] ref_rsp_data;
  logic       ref_last_inv;
  logic       ref_sync;

  task automatic ref_reset();
    ref_q.delete();
    ref_dout     = 4'd0;
    ref_rsp_data = 4'd0;
    ref_last_inv = 1'b0;
    ref_sync     = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one command (called at a negedge), check timing and response, then handshake.
  task automatic do_cmd(input logic [1:0] op, input logic [3:0] data, input int hold,
                        input bit keep_valid);
    int lat, en_cnt, rst_cnt, both, wt, bad, hold_en;
    logic inv, chk_inv, e_emp, e_full, mism;
    int sz;
    inv = 1'b0;
    chk_inv = 1'b0;
    case (op)
      OP_PUSH: begin
        if (ref_q.size() < 7) ref_q.push_back(data);
        else inv = 1'b1;
        ref_last_inv = inv;
        chk_inv = inv;
      end
      OP_POP: begin
        if (ref_q.size() > 0) ref_dout = ref_q.pop_back();
        else inv = 1'b1;
        ref_last_inv = inv;
        chk_inv = inv;
        ref_rsp_data = ref_dout;
      end
      OP_CLEAR: begin
        ref_q.delete();
        ref_dout = 4'd0;
        ref_last_inv = 1'b0;
      end
      default: inv = ref_last_inv;
    endcase
    sz     = ref_q.size();
    e_emp  = force_e0 ? 1'b0 : (sz == 0);
    e_full = (sz == 7);
    mism   = (e_emp != (sz == 0)) || (e_full != (sz == 7)) || (inv != chk_inv);
    ref_sync = (op == OP_CLEAR) ? mism : (ref_sync | mism);

    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    wt = 0;
    while (!cmd_ready && wt < 50) begin
      @(negedge clk);
      wt++;
    end
    if (!cmd_ready) begin
      check("accept_timeout", 32'(cmd_ready), 32'd1);
      return;
    end
    @(posedge clk);
    lat = 0; en_cnt = 0; rst_cnt = 0; both = 0;
    while (1) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      cmd_op    = 2'($urandom);
      cmd_data  = 4'($urandom);
      if (stk_enable) en_cnt++;
      if (stk_rst) rst_cnt++;
      if (stk_push && stk_pop) both++;
      if (rsp_valid || lat > 30) break;
      lat++;
    end
    check("latency", 32'(lat), (op == OP_STATUS) ? 32'd1 : 32'd4);
    if (!rsp_valid) return;
    check("enable_cycles", 32'(en_cnt), (op == OP_PUSH || op == OP_POP) ? 32'd2 : 32'd0);
    check("stkrst_cycles", 32'(rst_cnt), (op == OP_CLEAR) ? 32'd2 : 32'd0);
    check("push_pop_excl", 32'(both), 32'd0);
    check("rsp_data", 32'(rsp_data), 32'(ref_rsp_data));
    check("rsp_invalid", 32'(rsp_invalid), 32'(inv));
    check("rsp_empty", 32'(rsp_empty), 32'(e_emp));
    check("rsp_full", 32'(rsp_full), 32'(e_full));
    check("occupancy", 32'(occupancy), 32'(sz));
    check("sync_err", 32'(sync_err), 32'(ref_sync));

    if (hold > 0) begin
      bad = 0; hold_en = 0;
      if (keep_valid) begin
        cmd_valid = 1'b1;
        cmd_op    = OP_PUSH;
        cmd_data  = 4'h9;
      end
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        if (rsp_valid !== 1'b1 || rsp_data !== ref_rsp_data || rsp_invalid !== inv ||
            rsp_empty !== e_emp || rsp_full !== e_full || occupancy !== 4'(sz)) bad++;
        if (cmd_ready !== 1'b0) bad++;
        if (stk_enable || stk_push) hold_en++;
      end
      check("hold_stable", 32'(bad), 32'd0);
      check("hold_no_strobe", 32'(hold_en), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_valid_drop", 32'(rsp_valid), 32'd0);
    if (keep_valid) check("first_idle_ready", 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    int n;
    logic [1:0] rop;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_data = 4'h0; rsp_ready = 1'b0;
    ref_reset();
    repeat (3) @(negedge clk);
    check("rst_stk_rst", 32'(stk_rst), 32'd1);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_rsp_empty", 32'(rsp_empty), 32'd1);
    check("rst_occupancy", 32'(occupancy), 32'd0);
    check("rst_sync_err", 32'(sync_err), 32'd0);
    check("rst_enable", 32'(stk_enable), 32'd0);
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      n++;
      if (!stk_rst) break;
    end
    check("init_rst_cycles", 32'(n), 32'd2);
    check("init_ready", 32'(cmd_ready), 32'd1);

    // Basic LIFO order
    do_cmd(OP_PUSH, 4'hA, 0, 1'b0);
    do_cmd(OP_PUSH, 4'h5, 0, 1'b0);
    do_cmd(OP_POP, 4'h0, 0, 1'b0);
    do_cmd(OP_POP, 4'h0, 0, 1'b0);

    // Fill to capacity, overflow, then pop the top
    for (int i = 1; i <= 8; i++) do_cmd(OP_PUSH, 4'(i), 0, 1'b0);
    do_cmd(OP_POP, 4'h0, 0, 1'b0);
    do_cmd(OP_CLEAR, 4'h0, 0, 1'b0);

    // Underflow
    do_cmd(OP_POP, 4'h0, 0, 1'b0);

    // Stalled response with a pending command behind it
    do_cmd(OP_PUSH, 4'hB, 5, 1'b1);
    do_cmd(OP_PUSH, 4'h9, 0, 1'b0);
    do_cmd(OP_STATUS, 4'h0, 0, 1'b0);
    do_cmd(OP_CLEAR, 4'h0, 0, 1'b0);

    // Stack reporting a wrong empty flag
    force_e0 = 1'b1;
    do_cmd(OP_PUSH, 4'h2, 0, 1'b0);
    do_cmd(OP_POP, 4'h0, 0, 1'b0);
    do_cmd(OP_STATUS, 4'h0, 0, 1'b0);
    force_e0 = 1'b0;
    do_cmd(OP_CLEAR, 4'h0, 0, 1'b0);

    // Random traffic
    for (int i = 0; i < 60; i++) begin
      n = int'($urandom_range(0, 9));
      rop = (n < 4 || n == 9) ? OP_PUSH : (n < 7) ? OP_POP : (n == 7) ? OP_STATUS : OP_CLEAR;
      do_cmd(rop, 4'($urandom_range(0, 15)), int'($urandom_range(0, 2)), 1'b0);
    end

    // Reset during the strobe
    cmd_valid = 1'b1; cmd_op = OP_PUSH; cmd_data = 4'h3;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("mid_enable_high", 32'(stk_enable), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_enable", 32'(stk_enable), 32'd0);
    check("abort_stk_rst", 32'(stk_rst), 32'd1);
    check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    ref_reset();
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("reinit_ready", 32'(cmd_ready), 32'd1);
    do_cmd(OP_STATUS, 4'h0, 0, 1'b0);
    do_cmd(OP_PUSH, 4'hC, 0, 1'b0);
    do_cmd(OP_POP, 4'h0, 1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
